// File: rtl/mul_arbiter.sv
// Round-robin arbiter that shares one shift-add multiplier slave among NREQ requesters.
// It grants one requester, issues its operands, waits for completion or a watchdog timeout, and returns the product.
module mul_arbiter #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*16-1:0]   a_in,
  input  logic [NREQ*16-1:0]   b_in,
  output logic [NREQ-1:0]      gnt,
  output logic                 done,
  output logic [IDW-1:0]       resp_id,
  output logic [31:0]          result,
  output logic                 err,
  output logic                 busy,
  output logic                 valid_signal,
  output logic                 start_calc,
  output logic [15:0]          A_out,
  output logic [15:0]          B_out,
  input  logic [31:0]          read_data,
  input  logic                 ready_signal
);

  localparam int WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_LOW,
    S_WAIT_HIGH,
    S_RESP
  } state_t;

  // Slave handshake: valid_signal and start_calc pulse together for exactly one
  // cycle (ISSUE). ready_signal is a level from the slave; it must first be seen
  // low (WAIT_LOW) before a high level (WAIT_HIGH) counts as completion.
  state_t           state;
  state_t           state_nx;

  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   id;
  logic [WDW-1:0]   wd;

  logic             found;
  logic [IDW-1:0]   pick;
  logic [15:0]      a_sel;
  logic [15:0]      b_sel;
  logic             wd_expired;

  logic [NREQ-1:0]  gnt_d;
  logic [15:0]      a_d;
  logic [15:0]      b_d;
  logic [IDW-1:0]   id_d;
  logic [IDW-1:0]   ptr_d;
  logic             valid_d;
  logic             done_d;
  logic [IDW-1:0]   resp_id_d;
  logic [31:0]      result_d;
  logic             err_d;
  logic [WDW-1:0]   wd_d;

  assign busy       = (state != S_IDLE);
  assign wd_expired = (wd == WDW'(TIMEOUT - 1));

  // Rotating search: for distance i, only the requester at (ptr + i) mod NREQ
  // matches, so the first hit is the nearest set bit after ptr.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 1; i <= NREQ; i++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!found && req[k] && (ptr == IDW'((k - i + NREQ) % NREQ))) begin
          found = 1'b1;
          pick  = IDW'(k);
        end
      end
    end
  end

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (pick == IDW'(k)) begin
        a_sel = a_in[16*k +: 16];
        b_sel = b_in[16*k +: 16];
      end
    end
  end

  // State register together with all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      gnt          <= '0;
      A_out        <= '0;
      B_out        <= '0;
      id           <= '0;
      ptr          <= IDW'(NREQ - 1);
      valid_signal <= 1'b0;
      start_calc   <= 1'b0;
      done         <= 1'b0;
      resp_id      <= '0;
      result       <= '0;
      err          <= 1'b0;
      wd           <= '0;
    end else begin
      state        <= state_nx;
      gnt          <= gnt_d;
      A_out        <= a_d;
      B_out        <= b_d;
      id           <= id_d;
      ptr          <= ptr_d;
      valid_signal <= valid_d;
      start_calc   <= valid_d;
      done         <= done_d;
      resp_id      <= resp_id_d;
      result       <= result_d;
      err          <= err_d;
      wd           <= wd_d;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:      if (found) state_nx = S_ISSUE;
      S_ISSUE:     state_nx = S_WAIT_LOW;
      S_WAIT_LOW: begin
        if (!ready_signal)   state_nx = S_WAIT_HIGH;
        else if (wd_expired) state_nx = S_RESP;
      end
      S_WAIT_HIGH: begin
        if (ready_signal)    state_nx = S_RESP;
        else if (wd_expired) state_nx = S_RESP;
      end
      S_RESP:      state_nx = S_IDLE;
      default:     state_nx = S_IDLE;
    endcase
  end

  // Next values of the registered outputs, decoded from the current state and transition.
  always_comb begin
    gnt_d     = gnt;
    a_d       = A_out;
    b_d       = B_out;
    id_d      = id;
    ptr_d     = ptr;
    valid_d   = 1'b0;
    done_d    = 1'b0;
    resp_id_d = resp_id;
    result_d  = result;
    err_d     = err;
    wd_d      = wd;
    case (state)
      S_IDLE: begin
        if (found) begin
          gnt_d   = NREQ'(1) << pick;
          a_d     = a_sel;
          b_d     = b_sel;
          id_d    = pick;
          ptr_d   = pick;
          valid_d = 1'b1;
        end
      end
      S_ISSUE: wd_d = '0;
      S_WAIT_LOW, S_WAIT_HIGH: begin
        wd_d = wd + WDW'(1);
        if (state_nx == S_RESP) begin
          done_d    = 1'b1;
          resp_id_d = id;
          // Completion wins over a timeout landing in the same cycle.
          if (state == S_WAIT_HIGH && ready_signal) begin
            result_d = read_data;
            err_d    = 1'b0;
          end else begin
            err_d    = 1'b1;
          end
        end
      end
      S_RESP: gnt_d = '0;
      default: ;
    endcase
  end

endmodule

// File: doc/mul_arbiter.md
Name: mul_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one shift-add multiplier slave among NREQ requesters.
- Grants one requester at a time and latches its 16-bit operands.
- Drives the slave's valid/start handshake, waits for completion and captures the 32-bit product.
- Returns the product, the requester id and an error flag; a watchdog recovers the arbiter if the slave hangs.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of requester id; must equal clog2(NREQ).
- TIMEOUT, 64, max cycles in WAIT_LOW + WAIT_HIGH before abort.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester request level; held until own done.
- a_in  in  NREQ*16  operand A, requester k at bits [16k+15:16k].
- b_in  in  NREQ*16  operand B, same packing.
- gnt  out  NREQ  one-hot grant; held from grant until done.
- done  out  1  one-cycle completion pulse.
- resp_id  out  IDW  id of the finished requester; valid with done.
- result  out  32  product; valid with done, holds its value until the next done.
- err  out  1  timeout flag; valid with done.
- busy  out  1  high in every state except IDLE.
- valid_signal  out  1  to slave: operand/start strobe.
- start_calc  out  1  to slave: start bit, asserted together with valid_signal.
- A_out  out  16  to slave A_in.
- B_out  out  16  to slave B_in.
- read_data  in  32  from slave: product register.
- ready_signal  in  1  from slave: completion level.

Behaviour:
- Reset values (sync, rst=1 at a clk edge):
  - state=IDLE, gnt=0, done=0, resp_id=0, result=0, err=0, busy=0.
  - valid_signal=0, start_calc=0, A_out=0, B_out=0.
  - rr pointer = NREQ-1, so requester 0 has first priority.
  - Watchdog counter = 0.
- Reset mid-operation: abandons the transaction with no done pulse. The slave may still finish; its ready_signal is ignored until the next ISSUE.
- States: IDLE, ISSUE, WAIT_LOW, WAIT_HIGH, RESP.
- IDLE, req!=0:
  - Pick the first set req bit searching ptr+1, ptr+2, ... modulo NREQ.
  - Set gnt one-hot, latch that requester's a_in/b_in into A_out/B_out, record id, set ptr=id.
  - Go to ISSUE on the next edge.
  - req==0: stay in IDLE.
- ISSUE (exactly 1 cycle): valid_signal=1, start_calc=1; next state WAIT_LOW, watchdog cleared.
- WAIT_LOW: wait for ready_signal==0, which the slave drives the cycle after the strobe; then go to WAIT_HIGH. This prevents a stale ready=1 from the previous operation being taken as completion.
- WAIT_HIGH: on ready_signal==1, capture read_data into result with err=0, then go to RESP.
- Watchdog:
  - Increments each cycle in WAIT_LOW and WAIT_HIGH.
  - Reaching TIMEOUT → go to RESP with err=1 and result unchanged (keeps the previous value).
- RESP (1 cycle): done=1 and resp_id=id, then clear gnt and go to IDLE.
- Latency:
  - IDLE to done ≥ 20 cycles with the 16-step slave: grant 1, ISSUE 1, WAIT_LOW 1, slave compute ≈17, RESP 1.
  - The exact count is set by the slave; the bench checks that done follows ready_signal high by exactly 1 cycle.
- Requester rules:
  - req is sampled only in IDLE; changes to req while busy are ignored.
  - A requester keeping req high after its done is re-arbitrated at lowest priority. A non-granted waiter always wins next, so there is no starvation.
  - a_in/b_in must be stable in the grant cycle only.
- Simultaneous requests: resolved purely by rotation order. With all requesters high, the grant order is 0,1,2,3,0,...
- Widths:
  - Operands are passed unmodified; result = read_data, 32-bit, no truncation.
  - The arbiter does no arithmetic.
- Outputs are registered except busy, which may be decoded from state.

Test Plan:
1. Single request: req=0001, A=3, B=5 → one valid_signal/start_calc pulse with A_out=3, B_out=5; done with resp_id=0, result=read_data; err=0.
2. All four requesting, each held until its done → grants in order 0,1,2,3; exactly one gnt bit high at any time; four done pulses.
3. Fairness: req0 held permanently, req2 raised during req0's first transaction → next grant is 2, then 0.
4. Stale ready: ready_signal held at 1 from the previous op, then dropped 1 cycle after ISSUE → no early done; completion taken only on the next high.
5. Timeout: slave model never raises ready → done with err=1 at TIMEOUT cycles after ISSUE, result unchanged, arbiter back in IDLE and able to serve req1.
6. Reset during WAIT_HIGH → next cycle all outputs at reset values, no done; following request starts a fresh transaction with requester 0 first.
